axis_spm_config_writer: RTL
===========================

// Module: axis_spm_config_writer
// PURPOSE
//  Initiator side of the SPM config bus (config_addr/config_data) read by axis_spm_control and other RPSPMC blocks.
//  Accepts register-write frames from the PS as a 32-bit AXI-stream: address word first, then data words.
//  Assembles the data words into a 512-bit shadow and commits it by asserting config_addr for HOLD_CYCLES cycles.
//  After the commit, config_addr returns to IDLE_ADDR so receivers' address decoders auto-reset.
// PARAMETERS
//  CFG_WORDS    16  data words per frame max; config_data width = 32*CFG_WORDS
//  HOLD_CYCLES  1   cycles config_addr is held at the frame address (>=1)
//  IDLE_ADDR    0   config_addr value when no commit is active; frames addressed to it are discarded
// PORTS
//  a_clk               in   1    clock, all logic rising edge
//  a_resetn            in   1    asynchronous active-low reset
//  S_AXIS_CFG_tdata    in   32   frame word: address word, then data words
//  S_AXIS_CFG_tvalid   in   1    word valid
//  S_AXIS_CFG_tready   out  1    word accepted when tvalid&tready
//  S_AXIS_CFG_tlast    in   1    last word of frame
//  config_addr         out  32   register address; IDLE_ADDR except during commit
//  config_data         out  512  assembled payload; word k at [32k+31:32k]
//  busy                out  1    1 in every state except IDLE
//  error               out  1    sticky: frame overflow seen
//  clear_error         in   1    synchronous clear of error (wins over a simultaneous set)
//  commit_count        out  32   number of commits issued, wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset (async): state=IDLE, config_addr=IDLE_ADDR, config_data=0, tready=0, busy=0, error=0, commit_count=0.
//  tready registered; 1 in IDLE and DATA, 0 in COMMIT and GAP; goes 1 the first cycle after reset release.
//  IDLE: accepted word -> addr_reg; shadow cleared to 0; word index k=0.
//    tlast on address word -> COMMIT with all-zero data; else -> DATA.
//  DATA: accepted word k<CFG_WORDS -> shadow[k]; k++. k>=CFG_WORDS -> word dropped, error<=1.
//    Accepted word with tlast -> COMMIT (or IDLE if addr_reg==IDLE_ADDR).
//  Frames with addr_reg==IDLE_ADDR are consumed fully, produce no commit, do not bump commit_count.
//  COMMIT: on entry cycle config_data<=shadow and config_addr<=addr_reg in the same edge
//    (data never changes while config_addr is non-idle); held HOLD_CYCLES cycles; commit_count++ once at entry.
//  GAP: config_addr<=IDLE_ADDR for exactly 1 cycle, config_data retained, -> IDLE.
//    Guarantees two identical back-to-back addresses are seen as separate writes.
//  config_data keeps last committed value between commits; only changes at COMMIT entry.
//  Latency: tlast word accepted at edge N -> config_addr valid from edge N+1 for HOLD_CYCLES cycles.
//  Min frame spacing: HOLD_CYCLES+1 cycles of tready=0 after each committed frame.
//  tvalid gaps inside a frame: allowed, no timeout; state/index held.
//  Reset asserted mid-frame or mid-commit: partial frame discarded, outputs to reset values immediately.
// TESTING
//  1 addr 1100, data 1..6, tlast on 6 -> config_addr=1100 for 1 cycle, data[191:0]=6..1 packed, [511:192]=0, commit_count=1.
//  2 two frames 1101 {A,B} then 1101 {C,D} back-to-back tvalid=1 -> two commits with 1 idle cycle between, tready low 2 cycles each.
//  3 addr 1102 with 17 data words -> first 16 committed, 17th dropped, error=1; clear_error pulse -> error=0.
//  4 addr 0 frame with 3 words -> no commit, commit_count unchanged, next frame commits normally.
//  5 a_resetn low after 3 data words of a frame, release, send addr 1103 {5} -> only 1103 committed, data[31:0]=5.
//  6 HOLD_CYCLES=4, random tvalid gaps -> config_addr held exactly 4 cycles, data stable whole hold.

Source files
------------

// File: rtl/axis_spm_config_writer.sv
// AXI-stream to SPM config bus initiator: assembles address+data frames into a
// wide shadow and commits them as a held config_addr pulse followed by an idle gap.
module axis_spm_config_writer #(
  parameter int unsigned CFG_WORDS   = 16,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter logic [31:0] IDLE_ADDR   = 32'h0000_0000
) (
  input  logic                      a_clk,
  input  logic                      a_resetn,
  input  logic [31:0]               S_AXIS_CFG_tdata,
  input  logic                      S_AXIS_CFG_tvalid,
  output logic                      S_AXIS_CFG_tready,
  input  logic                      S_AXIS_CFG_tlast,
  output logic [31:0]               config_addr,
  output logic [32*CFG_WORDS-1:0]   config_data,
  output logic                      busy,
  output logic                      error,
  input  logic                      clear_error,
  output logic [31:0]               commit_count
);

  localparam int unsigned DATA_W = 32 * CFG_WORDS;
  localparam int unsigned IDX_W  = $clog2(CFG_WORDS + 1);
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_COMMIT = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                tready_q, tready_d;
  logic [31:0]         cfg_addr_q, cfg_addr_d;
  logic [DATA_W-1:0]   cfg_data_q, cfg_data_d;
  logic                busy_q, busy_d;
  logic                error_q, error_d;
  logic [31:0]         count_q, count_d;
  logic                err_set;
  logic                accept_c;

  assign accept_c = S_AXIS_CFG_tvalid & tready_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    count_d    = count_q;
    err_set    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          addr_d   = S_AXIS_CFG_tdata;
          shadow_d = '0;
          idx_d    = '0;
          if (!S_AXIS_CFG_tlast) begin
            state_d = S_DATA;
          end else if (S_AXIS_CFG_tdata != IDLE_ADDR) begin
            state_d    = S_COMMIT;
            cfg_addr_d = S_AXIS_CFG_tdata;
            cfg_data_d = '0;
            count_d    = count_q + 32'd1;
            hold_d     = HOLD_W'(HOLD_CYCLES - 1);
          end
        end
      end

      S_DATA: begin
        if (accept_c) begin
          if (idx_q < IDX_W'(CFG_WORDS)) begin
            for (int unsigned k = 0; k < CFG_WORDS; k++) begin
              if (idx_q == IDX_W'(k)) shadow_d[k*32 +: 32] = S_AXIS_CFG_tdata;
            end
            idx_d = idx_q + IDX_W'(1);
          end else begin
            err_set = 1'b1;
          end
          if (S_AXIS_CFG_tlast) begin
            if (addr_q == IDLE_ADDR) begin
              state_d = S_IDLE;
            end else begin
              // Address and payload launch on the same edge so data is stable under the pulse
              state_d    = S_COMMIT;
              cfg_addr_d = addr_q;
              cfg_data_d = shadow_d;
              count_d    = count_q + 32'd1;
              hold_d     = HOLD_W'(HOLD_CYCLES - 1);
            end
          end
        end
      end

      S_COMMIT: begin
        if (hold_q == '0) begin
          state_d    = S_GAP;
          cfg_addr_d = IDLE_ADDR;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      S_GAP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d    = S_IDLE;
        cfg_addr_d = IDLE_ADDR;
      end
    endcase

    tready_d = (state_d == S_IDLE) || (state_d == S_DATA);
    busy_d   = (state_d != S_IDLE);
    error_d  = clear_error ? 1'b0 : (error_q | err_set);
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= IDLE_ADDR;
      shadow_q   <= '0;
      idx_q      <= '0;
      hold_q     <= '0;
      tready_q   <= 1'b0;
      cfg_addr_q <= IDLE_ADDR;
      cfg_data_q <= '0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      tready_q   <= tready_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
      count_q    <= count_d;
    end
  end

  assign S_AXIS_CFG_tready = tready_q;
  assign config_addr       = cfg_addr_q;
  assign config_data       = cfg_data_q;
  assign busy              = busy_q;
  assign error             = error_q;
  assign commit_count      = count_q;

endmodule
